svc_soc_io_uart_rx: RTL and testbench



---
 rtl/svc_soc_io_uart_rx.sv | 207 ++++++++++++++++++++
 tb/tb_svc_soc_io_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/svc_soc_io_uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// DATA/STATUS registers sit on the SoC I/O bus; read data is OR-combinable.
module svc_soc_io_uart_rx #(
  parameter int unsigned CLOCK_FREQ = 25_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0100,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        rx_irq
);

  localparam int unsigned CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned TW  = $clog2(CPB);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);
  localparam logic [PW:0]   DEPTH  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_m;
  logic          rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          overrun;
  logic          framing;

  logic not_empty;
  logic full;
  logic stop_tick;
  logic push;
  logic push_ok;
  logic pop;
  logic ov_set;
  logic fr_set;
  logic stat_wr;
  logic ov_clr;
  logic fr_clr;
  logic unused_bits;

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH);
  assign stop_tick = (state == STOP) && (timer == '0);
  assign push      = stop_tick && rx_s;
  assign fr_set    = stop_tick && !rx_s;
  assign pop       = io_ren && (io_raddr == BASE_ADDR) && not_empty;
  assign push_ok   = push && (!full || pop);
  assign ov_set    = push && full && !pop;
  assign stat_wr   = io_wen && (io_waddr == STAT_ADDR) && io_wstrb[0];
  assign ov_clr    = stat_wr && io_wdata[1];
  assign fr_clr    = stat_wr && io_wdata[2];
  assign rx_irq    = not_empty;

  assign unused_bits = ^{io_wdata[31:3], io_wdata[0], io_wstrb[3:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= T_HALF;
          end
        end
        START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (!rx_s) begin
            state   <= DATA;
            bit_idx <= '0;
            timer   <= T_FULL;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            timer <= T_FULL;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (ov_set) begin
        overrun <= 1'b1;
      end else if (ov_clr) begin
        overrun <= 1'b0;
      end
      if (fr_set) begin
        framing <= 1'b1;
      end else if (fr_clr) begin
        framing <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata <= '0;
    end else begin
      io_rdata <= '0;
      if (io_ren && io_raddr == BASE_ADDR && not_empty) begin
        io_rdata <= {23'b0, 1'b1, mem[rd_ptr]};
      end else if (io_ren && io_raddr == STAT_ADDR) begin
        io_rdata <= {28'b0, full, framing, overrun, not_empty};
      end
    end
  end

endmodule

// File: tb/tb_svc_soc_io_uart_rx.sv
// Directed bench for svc_soc_io_uart_rx at 16 clocks per bit.
// Frames are driven on the negedge; outputs are sampled on the negedge.
module tb_svc_soc_io_uart_rx;

  localparam logic [31:0] BASE = 32'h8000_0100;
  localparam logic [31:0] STAT = 32'h8000_0104;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  svc_soc_io_uart_rx #(
    .CLOCK_FREQ(16),
    .BAUD_RATE (1),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .io_ren  (io_ren),
    .io_raddr(io_raddr),
    .io_rdata(io_rdata),
    .io_wen  (io_wen),
    .io_waddr(io_waddr),
    .io_wdata(io_wdata),
    .io_wstrb(io_wstrb),
    .rx_irq  (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    line(1'b0, 16);
    for (int i = 0; i < nbits; i++) begin
      line(b[i], 16);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    line(1'b1, 16);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    io_ren   = 1'b1;
    io_raddr = a;
    @(negedge clk);
    io_ren   = 1'b0;
    io_raddr = '0;
    d = io_rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    io_wen   = 1'b1;
    io_waddr = a;
    io_wdata = d;
    io_wstrb = 4'hF;
    @(negedge clk);
    io_wen   = 1'b0;
    io_waddr = '0;
    io_wdata = '0;
    io_wstrb = '0;
  endtask

  logic [31:0] d;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    bus_read(STAT, d);
    check("reset_status", d, 32'h0);

    // Single frame 0xA5, watching rx_irq around the stop sample.
    send_bits(8'hA5, 8);
    line(1'b1, 8);
    check("irq_before_stop", {31'b0, rx_irq}, 32'h0);
    line(1'b1, 4);
    check("irq_after_stop", {31'b0, rx_irq}, 32'h1);
    line(1'b1, 4);
    bus_read(STAT, d);
    check("a5_status", d, 32'h1);
    bus_read(BASE, d);
    check("a5_data", d, 32'h1A5);
    @(negedge clk);
    check("rdata_idle", io_rdata, 32'h0);
    bus_read(STAT, d);
    check("a5_status_empty", d, 32'h0);
    check("a5_irq_low", {31'b0, rx_irq}, 32'h0);
    bus_read(32'h8000_0200, d);
    check("other_addr", d, 32'h0);

    // Back-to-back frames.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    line(1'b1, 4);
    bus_read(BASE, d);
    check("b2b_0", d, 32'h100);
    bus_read(BASE, d);
    check("b2b_1", d, 32'h1FF);
    bus_read(BASE, d);
    check("b2b_2", d, 32'h155);

    // Overrun: nine frames into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
    end
    line(1'b1, 4);
    bus_read(STAT, d);
    check("ovr_status", d, 32'hB);
    bus_write(STAT, 32'h2);
    bus_read(STAT, d);
    check("ovr_cleared", d, 32'h9);
    for (int i = 1; i <= 8; i++) begin
      bus_read(BASE, d);
      check("ovr_data", d, 32'h100 | 32'(i));
    end
    bus_read(STAT, d);
    check("ovr_drained", d, 32'h0);

    // Framing error followed by a held-low line.
    send_bits(8'h00, 8);
    line(1'b0, 16);
    line(1'b0, 40);
    line(1'b1, 8);
    bus_read(STAT, d);
    check("frm_status", d, 32'h4);
    send_byte(8'h3C);
    line(1'b1, 4);
    bus_read(BASE, d);
    check("frm_next_data", d, 32'h13C);
    bus_write(STAT, 32'h4);
    bus_read(STAT, d);
    check("frm_cleared", d, 32'h0);

    // Short glitch must not start a frame.
    line(1'b0, 4);
    line(1'b1, 30);
    bus_read(BASE, d);
    check("glitch_data", d, 32'h0);
    bus_read(STAT, d);
    check("glitch_status", d, 32'h0);

    // Reset mid-frame with a byte queued; remaining bits keep line high.
    send_byte(8'h77);
    bus_write(STAT, 32'h0);
    send_bits(8'hF0, 4);
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_irq", {31'b0, rx_irq}, 32'h0);
    bus_read(STAT, d);
    check("rst_status", d, 32'h0);
    line(1'b1, 80);
    send_byte(8'h81);
    line(1'b1, 4);
    bus_read(BASE, d);
    check("rst_next_data", d, 32'h181);
    bus_read(STAT, d);
    check("rst_end_status", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
